// File: rtl/cnn_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cnn_pkg : shared constants and types for the CNN adder-path feeder  (rev 1.0)
// ---------------------------------------------------------------------------
package cnn_pkg;

  localparam int DW        = 8;
  localparam int SUM_W     = 10;
  localparam int IMG_W_DEF = 8;
  localparam int IMG_H_DEF = 8;

  typedef logic [DW-1:0] pixel_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pixel_regfile : frame store, one sync write port, three async read ports  (rev 1.0)
// ---------------------------------------------------------------------------
module pixel_regfile
  import cnn_pkg::*;
#(
  parameter int DW    = cnn_pkg::DW,
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  input  logic [AW-1:0] rd_addr3,
  output logic [DW-1:0] rd_data1,
  output logic [DW-1:0] rd_data2,
  output logic [DW-1:0] rd_data3
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data1 = mem[rd_addr1];
  assign rd_data2 = mem[rd_addr2];
  assign rd_data3 = mem[rd_addr3];

endmodule
`default_nettype wire

// File: rtl/cnn_tap_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cnn_tap_feeder : loads a pixel frame, then streams vertical 3-tap columns  (rev 1.0)
// ---------------------------------------------------------------------------
module cnn_tap_feeder
  import cnn_pkg::*;
#(
  parameter  int IMG_W = cnn_pkg::IMG_W_DEF,
  parameter  int IMG_H = cnn_pkg::IMG_H_DEF,
  parameter  int DW    = cnn_pkg::DW,
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] data1,
  output logic [DW-1:0] data2,
  output logic [DW-1:0] data3,
  output logic          out_valid,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          sum_valid,
  output logic          frame_done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX);

  localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 3);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] ld_cnt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          wr_en;
  logic          emit;
  logic          last_shown;
  logic [AW-1:0] addr1;
  logic [AW-1:0] addr2;
  logic [AW-1:0] addr3;
  logic [DW-1:0] tap1;
  logic [DW-1:0] tap2;
  logic [DW-1:0] tap3;

  // SCAN holds one extra cycle after the final triple so frame_done and DONE coincide.
  assign last_shown = out_valid && (out_row == LAST_ROW) && (out_col == LAST_COL);
  assign wr_en      = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    emit      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (ld_cnt == LAST_PIX)) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (last_shown) begin
          state_nxt = DONE;
        end else begin
          emit = 1'b1;
        end
      end
      DONE:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt <= '0;
      row    <= '0;
      col    <= '0;
    end else begin
      if (wr_en) begin
        ld_cnt <= (ld_cnt == LAST_PIX) ? '0 : ld_cnt + AW'(1);
      end
      if (emit) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  assign addr1 = AW'(row) * ROW_STEP + AW'(col);
  assign addr2 = addr1 + ROW_STEP;
  assign addr3 = addr2 + ROW_STEP;

  pixel_regfile #(
    .DW    (DW),
    .DEPTH (NPIX),
    .AW    (AW)
  ) u_regfile (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_addr  (ld_cnt),
    .wr_data  (in_data),
    .rd_addr1 (addr1),
    .rd_addr2 (addr2),
    .rd_addr3 (addr3),
    .rd_data1 (tap1),
    .rd_data2 (tap2),
    .rd_data3 (tap3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data1      <= '0;
      data2      <= '0;
      data3      <= '0;
      out_row    <= '0;
      out_col    <= '0;
      out_valid  <= 1'b0;
      sum_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= emit;
      sum_valid  <= out_valid;
      frame_done <= (state == SCAN) && last_shown;
      if (emit) begin
        data1   <= tap1;
        data2   <= tap2;
        data3   <= tap3;
        out_row <= row;
        out_col <= col;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cnn_tap_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cnn_tap_feeder : feeder plus registered 3-input adder vs. timeline model  (rev 1.0)
// ---------------------------------------------------------------------------
module tb_cnn_tap_feeder;
  import cnn_pkg::*;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int NT   = (H - 2) * W;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          in_ready;
  logic [DW-1:0] data1, data2, data3;
  logic          out_valid, sum_valid, frame_done;
  logic [1:0]    out_row, out_col;
  logic [SUM_W-1:0] sum_q;

  cnn_tap_feeder #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .data1      (data1),
    .data2      (data2),
    .data3      (data3),
    .out_valid  (out_valid),
    .out_row    (out_row),
    .out_col    (out_col),
    .sum_valid  (sum_valid),
    .frame_done (frame_done)
  );

  // The existing registered adder downstream of the feeder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= SUM_W'(data1) + SUM_W'(data2) + SUM_W'(data3);
  end

  always #5 clk = ~clk;

  // Timeline model: t<0 while loading, else edges since the last pixel was taken.
  int     t;
  int     acc;
  pixel_t buffer [NPIX];
  pixel_t src [NPIX];
  int     e_d1, e_d2, e_d3, e_row, e_col, e_sum;
  bit     e_ov, e_fd, e_sv;
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    t = -1; acc = 0;
    e_d1 = 0; e_d2 = 0; e_d3 = 0; e_row = 0; e_col = 0; e_sum = 0;
    e_ov = 0; e_fd = 0; e_sv = 0;
  endtask

  task automatic check_all();
    check_val("in_ready",   in_ready,   (t < 0));
    check_val("out_valid",  out_valid,  e_ov);
    check_val("sum_valid",  sum_valid,  e_sv);
    check_val("frame_done", frame_done, e_fd);
    check_val("data1",      data1,      e_d1);
    check_val("data2",      data2,      e_d2);
    check_val("data3",      data3,      e_d3);
    check_val("out_row",    out_row,    e_row);
    check_val("out_col",    out_col,    e_col);
    if (e_sv) check_val("adder_sum", sum_q, e_sum);
  endtask

  task automatic step(input bit v, input logic [7:0] d);
    int idx;
    bit prev_ov;
    int prev_sum;
    prev_ov  = e_ov;
    prev_sum = e_d1 + e_d2 + e_d3;
    in_valid = v;
    in_data  = d;
    if (t < 0) begin
      if (v) begin
        buffer[acc] = d;
        acc++;
        if (acc == NPIX) begin
          acc = 0;
          t   = 0;
        end
      end
    end else begin
      t++;
      if (t <= NT) begin
        idx   = t - 1;
        e_row = idx / W;
        e_col = idx % W;
        e_d1  = buffer[e_row * W + e_col];
        e_d2  = buffer[(e_row + 1) * W + e_col];
        e_d3  = buffer[(e_row + 2) * W + e_col];
        e_ov  = 1;
      end else if (t == NT + 1) begin
        e_ov = 0;
        e_fd = 1;
      end else begin
        e_fd = 0;
        t    = -1;
      end
    end
    e_sv  = prev_ov;
    e_sum = prev_sum;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
  endtask

  // gap_mode: 0 = valid held high, 1 = 1,0,0 pattern, else random.
  task automatic send_frame(input int gap_mode);
    int i;
    int cyc;
    bit v;
    bit will;
    i   = 0;
    cyc = 0;
    while (i < NPIX && cyc < 500) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      will = v && (t < 0);
      step(v, v ? src[i] : 8'($urandom));
      if (will) i++;
      cyc++;
    end
    if (i < NPIX) check_val("send_timeout", i, NPIX);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) src[i] = 8'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // basic frame 0..15
    for (int i = 0; i < NPIX; i++) src[i] = 8'(i);
    send_frame(0);
    idle(NT + 3);

    // stream gaps, same pixels
    send_frame(1);
    idle(NT + 3);

    // input held at 0xAA during SCAN and DONE
    fill_random();
    send_frame(0);
    for (int i = 0; i < NT + 2; i++) step(1'b1, 8'hAA);
    fill_random();
    src[0] = 8'hAA;
    send_frame(0);
    idle(NT + 3);

    // maximum values
    for (int i = 0; i < NPIX; i++) src[i] = 8'hFF;
    send_frame(2);
    idle(NT + 3);

    // reset mid-load
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom));
    do_reset();
    for (int i = 0; i < NPIX; i++) src[i] = 8'(100 + i);
    send_frame(0);
    idle(NT + 3);

    // back-to-back frames
    fill_random();
    send_frame(0);
    fill_random();
    send_frame(0);
    idle(NT + 3);

    // reset in the middle of a scan
    fill_random();
    send_frame(0);
    idle(3);
    do_reset();

    // random frames
    for (int f = 0; f < 6; f++) begin
      fill_random();
      send_frame(2);
      idle($urandom_range(0, NT + 4));
    end
    idle(NT + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
